// File: rtl/encoding_cont_if.sv
// Message/codeword bus between the message source and the RS(15,9) encoder controller.
interface encoding_cont_if;
    logic [35:0] message;
    logic        encodeMessage;
    logic [59:0] codeWordVector;
    logic        encoderBusy;

    modport master (
        output message,
        output encodeMessage,
        input  codeWordVector,
        input  encoderBusy
    );

    modport slave (
        input  message,
        input  encodeMessage,
        output codeWordVector,
        output encoderBusy
    );
endinterface

// File: rtl/encoding_cont.sv
// Systematic RS(15,9) encoder over GF(16): serial LFSR parity generation, one symbol per clock,
// with a registered 60-bit codeword and a busy flag.
module encoding_cont (
    input  logic            clk,
    input  logic            rst,
    encoding_cont_if.slave  bus
);
    localparam int unsigned SYM_W = 4;
    localparam int unsigned K     = 9;
    localparam int unsigned NPAR  = 6;
    localparam int unsigned MSG_W = K * SYM_W;
    localparam int unsigned CW_W  = MSG_W + NPAR * SYM_W;
    localparam int unsigned CNT_W = 4;

    // Generator coefficients g5..g0 (monic x^6 term implicit).
    localparam logic [NPAR-1:0][SYM_W-1:0] GEN = {4'h7, 4'h9, 4'h3, 4'hC, 4'hA, 4'hC};

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                        state, next_state;
    logic [MSG_W-1:0]              msg_sr;
    logic [NPAR-1:0][SYM_W-1:0]    par, par_nxt;
    logic [CNT_W-1:0]              cnt;
    logic [CW_W-1:0]               cw;
    logic                          busy;
    logic [SYM_W-1:0]              fb;

    // Multiply by a constant in GF(16), x^4+x+1; constant operands fold into an XOR network.
    function automatic logic [SYM_W-1:0] gf_mul(input logic [SYM_W-1:0] a,
                                                input logic [SYM_W-1:0] b);
        logic [SYM_W-1:0] acc;
        logic [SYM_W-1:0] x;
        acc = '0;
        x   = a;
        for (int i = 0; i < int'(SYM_W); i++) begin
            if (b[i]) acc = acc ^ x;
            x = {x[SYM_W-2:0], 1'b0} ^ (x[SYM_W-1] ? 4'h3 : 4'h0);
        end
        return acc;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (bus.encodeMessage) next_state = SHIFT;
            SHIFT:   if (cnt == CNT_W'(K - 1)) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // One LFSR division step with the top message symbol.
    always_comb begin
        fb         = msg_sr[MSG_W-1 -: SYM_W] ^ par[NPAR-1];
        par_nxt    = '0;
        par_nxt[0] = gf_mul(fb, GEN[0]);
        for (int i = 1; i < int'(NPAR); i++) begin
            par_nxt[i] = par[i-1] ^ gf_mul(fb, GEN[i]);
        end
    end

    // Message register rotates a full turn over nine shifts, so it is intact again at DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            msg_sr <= '0;
            par    <= '0;
            cnt    <= '0;
            cw     <= '0;
            busy   <= 1'b0;
        end else begin
            busy <= (next_state != IDLE);
            unique case (state)
                IDLE: begin
                    if (bus.encodeMessage) begin
                        msg_sr <= bus.message;
                        par    <= '0;
                        cnt    <= '0;
                    end
                end
                SHIFT: begin
                    msg_sr <= {msg_sr[MSG_W-SYM_W-1:0], msg_sr[MSG_W-1 -: SYM_W]};
                    par    <= par_nxt;
                    cnt    <= cnt + CNT_W'(1);
                end
                DONE:    cw <= {msg_sr, par};
                default: ;
            endcase
        end
    end

    assign bus.codeWordVector = cw;
    assign bus.encoderBusy    = busy;
endmodule

// File: tb/tb_encoding_cont.sv
// Self-checking bench for encoding_cont: spec vectors, random messages against a polynomial-division model,
// busy-window timing, ignored requests, back-to-back encodes and asynchronous reset.
module tb_encoding_cont;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    encoding_cont_if bus();
    encoding_cont dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [35:0] msg;
        logic [59:0] cw;
    } vec_t;

    logic [3:0] gexp[15];
    int         glog[16];
    logic [3:0] gpoly[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] tmul(input logic [3:0] a, input logic [3:0] b);
        if (a == 4'h0 || b == 4'h0) return 4'h0;
        return gexp[(glog[a] + glog[b]) % 15];
    endfunction

    // Antilog/log tables for alpha=2 and g(x) as the product of (x + alpha^i), i=1..6.
    task automatic build_field();
        int v;
        v = 1;
        for (int i = 0; i < 15; i++) begin
            gexp[i] = 4'(v);
            glog[v] = i;
            v = v << 1;
            if (v >= 16) v = v ^ 'h13;
        end
        for (int d = 0; d < 7; d++) gpoly[d] = 4'h0;
        gpoly[0] = 4'h1;
        for (int i = 1; i <= 6; i++) begin
            for (int d = 6; d >= 1; d--) gpoly[d] = gpoly[d-1] ^ tmul(gpoly[d], gexp[i]);
            gpoly[0] = tmul(gpoly[0], gexp[i]);
        end
    endtask

    // Long division of m(x)*x^6 by g(x); remainder is the parity.
    function automatic logic [59:0] model(input logic [35:0] msg);
        logic [3:0]  c[15];
        logic [3:0]  q;
        logic [23:0] p;
        for (int d = 0; d < 15; d++) c[d] = 4'h0;
        for (int d = 0; d < 9; d++) c[d+6] = msg[4*d +: 4];
        for (int d = 14; d >= 6; d--) begin
            q = c[d];
            for (int j = 0; j < 7; j++) c[d-6+j] = c[d-6+j] ^ tmul(q, gpoly[j]);
        end
        for (int d = 0; d < 6; d++) p[4*d +: 4] = c[d];
        return {msg, p};
    endfunction

    // Pulse a request, then count negedge samples with busy high (bounded).
    task automatic run_encode(input logic [35:0] msg, output int width);
        @(negedge clk);
        bus.message       = msg;
        bus.encodeMessage = 1'b1;
        @(negedge clk);
        bus.encodeMessage = 1'b0;
        width = 0;
        while (bus.encoderBusy && width < 50) begin
            width++;
            @(negedge clk);
        end
    endtask

    initial begin
        vec_t        vecs[3];
        int          w, lo, seen;
        logic [35:0] m;

        build_field();
        vecs[0] = '{36'h000000000, 60'h000000000000000};
        vecs[1] = '{36'h000000001, 60'h000000001793CAC};
        vecs[2] = '{36'h0000000E0, 60'h0000000E057395F};

        rst = 1'b1;
        bus.message = '0;
        bus.encodeMessage = 1'b0;
        #3;
        check("reset_busy", 64'(bus.encoderBusy), 64'd0);
        check("reset_cw", 64'(bus.codeWordVector), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 3; i++) begin
            run_encode(vecs[i].msg, w);
            check($sformatf("vec%0d_width", i), 64'(w), 64'd10);
            check($sformatf("vec%0d_cw", i), 64'(bus.codeWordVector), 64'(vecs[i].cw));
        end

        // Request and message change mid-encode are ignored.
        @(negedge clk);
        bus.message = 36'h000000001;
        bus.encodeMessage = 1'b1;
        @(negedge clk);
        bus.encodeMessage = 1'b0;
        w = 0;
        while (bus.encoderBusy && w < 50) begin
            w++;
            if (w == 3) begin
                bus.message = 36'hFFFFFFFFF;
                bus.encodeMessage = 1'b1;
            end else begin
                bus.encodeMessage = 1'b0;
            end
            @(negedge clk);
        end
        check("ignore_width", 64'(w), 64'd10);
        check("ignore_cw", 64'(bus.codeWordVector), 64'h000000001793CAC);
        @(negedge clk);
        check("ignore_no_restart", 64'(bus.encoderBusy), 64'd0);

        for (int i = 0; i < 16; i++) begin
            m = 36'({$urandom(), $urandom()});
            run_encode(m, w);
            check($sformatf("rand%0d_width", i), 64'(w), 64'd10);
            check($sformatf("rand%0d_cw", i), 64'(bus.codeWordVector), 64'(model(m)));
        end

        // Request held high: 10 busy, 1 idle, repeating.
        @(negedge clk);
        bus.message = 36'h000000001;
        bus.encodeMessage = 1'b1;
        @(negedge clk);
        for (int r = 0; r < 3; r++) begin
            w = 0;
            while (bus.encoderBusy && w < 50) begin
                w++;
                @(negedge clk);
            end
            check($sformatf("hold%0d_width", r), 64'(w), 64'd10);
            check($sformatf("hold%0d_cw", r), 64'(bus.codeWordVector), 64'h000000001793CAC);
            lo = 0;
            while (!bus.encoderBusy && lo < 50) begin
                lo++;
                @(negedge clk);
            end
            check($sformatf("hold%0d_gap", r), 64'(lo), 64'd1);
        end
        bus.encodeMessage = 1'b0;
        w = 0;
        while (bus.encoderBusy && w < 50) begin
            w++;
            @(negedge clk);
        end

        // Asynchronous reset mid-encode.
        run_encode_start: begin
            @(negedge clk);
            bus.message = 36'h123456789;
            bus.encodeMessage = 1'b1;
            @(negedge clk);
            bus.encodeMessage = 1'b0;
            repeat (4) @(negedge clk);
        end
        check("pre_reset_busy", 64'(bus.encoderBusy), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("async_reset_busy", 64'(bus.encoderBusy), 64'd0);
        check("async_reset_cw", 64'(bus.codeWordVector), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus.encoderBusy || bus.codeWordVector != 60'h0) seen++;
        end
        check("aborted_never_completes", 64'(seen), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
